// File: rtl/evm_pkg.sv
// evm_pkg: shared widths, candidate count and FSM encoding
// for the EVM result reader (optional feature: EVM_READER_WINNER_EN).
package evm_pkg;

  localparam int NUM_CAND = 6;
  localparam int VOTE_W   = 8;
  localparam int TOTAL_W  = 11;
  localparam int IDX_W    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PRESS,
    S_SETTLE,
    S_CAPTURE,
    S_FINISH
  } state_e;

  function automatic logic [NUM_CAND-1:0] cand_onehot(
    input logic [IDX_W-1:0] idx
  );
    return NUM_CAND'(1) << idx;
  endfunction

endpackage

// File: rtl/evm_reader_timer.sv
// evm_reader_timer: loadable down-counter that stops at zero.
// Times the button hold and the post-release settle window.
module evm_reader_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A load wins over counting; the count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/evm_result_reader.sv
// evm_result_reader: presses each candidate button in result mode and
// captures the six tallies. Define EVM_READER_WINNER_EN for winner outputs.
module evm_result_reader
  import evm_pkg::*;
#(
  parameter int HOLD_CYCLES   = 12,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [VOTE_W-1:0]   result_in,
  output logic                mode_out,
  output logic [NUM_CAND-1:0] cand_btn,
  output logic                busy,
  output logic                tally_valid,
  output logic [IDX_W-1:0]    tally_idx,
  output logic [VOTE_W-1:0]   tally_data,
  output logic                done,
  output logic [TOTAL_W-1:0]  total
`ifdef EVM_READER_WINNER_EN
  ,
  output logic [IDX_W-1:0]    winner_idx,
  output logic [VOTE_W-1:0]   winner_votes
`endif
);

  localparam int MAX_CYC =
    (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int TW = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TOTAL_W-1:0]  total_q, total_d;
  logic [VOTE_W-1:0]   tdata_q, tdata_d;
  logic [IDX_W-1:0]    tidx_q, tidx_d;
  logic                tv_q, tv_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                mode_q, mode_d;
  logic [NUM_CAND-1:0] btn_q, btn_d;
`ifdef EVM_READER_WINNER_EN
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [VOTE_W-1:0]   wvot_q, wvot_d;
`endif

  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_zero;

  evm_reader_timer #(
    .W (TW)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  // Next-state and next-output logic; outputs follow the next state
  // so mode and buttons change on the same edge as the FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    total_d = total_q;
    tdata_d = tdata_q;
    tidx_d  = tidx_q;
    tv_d    = 1'b0;
    done_d  = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
`ifdef EVM_READER_WINNER_EN
    widx_d  = widx_q;
    wvot_d  = wvot_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          idx_d   = '0;
          total_d = '0;
`ifdef EVM_READER_WINNER_EN
          widx_d  = '0;
          wvot_d  = '0;
`endif
        end
      end
      S_ARM: begin
        state_d = S_PRESS;
        t_load  = 1'b1;
        t_val   = HOLD_LD;
      end
      S_PRESS: begin
        if (t_zero) begin
          state_d = S_SETTLE;
          t_load  = 1'b1;
          t_val   = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (t_zero) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        tdata_d = result_in;
        tidx_d  = idx_q;
        tv_d    = 1'b1;
        total_d = total_q + TOTAL_W'(result_in);
`ifdef EVM_READER_WINNER_EN
        if (result_in > wvot_q) begin
          widx_d = idx_q;
          wvot_d = result_in;
        end
`endif
        if (idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_PRESS;
          t_load  = 1'b1;
          t_val   = HOLD_LD;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    mode_d = busy_d;
    btn_d  = (state_d == S_PRESS) ? cand_onehot(idx_d) : '0;
  end

  // FSM and registered outputs; reset aborts and releases buttons.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      total_q <= '0;
      tdata_q <= '0;
      tidx_q  <= '0;
      tv_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mode_q  <= 1'b0;
      btn_q   <= '0;
`ifdef EVM_READER_WINNER_EN
      widx_q  <= '0;
      wvot_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      tdata_q <= tdata_d;
      tidx_q  <= tidx_d;
      tv_q    <= tv_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mode_q  <= mode_d;
      btn_q   <= btn_d;
`ifdef EVM_READER_WINNER_EN
      widx_q  <= widx_d;
      wvot_q  <= wvot_d;
`endif
    end
  end

  assign mode_out    = mode_q;
  assign cand_btn    = btn_q;
  assign busy        = busy_q;
  assign tally_valid = tv_q;
  assign tally_idx   = tidx_q;
  assign tally_data  = tdata_q;
  assign done        = done_q;
  assign total       = total_q;
`ifdef EVM_READER_WINNER_EN
  assign winner_idx   = widx_q;
  assign winner_votes = wvot_q;
`endif

endmodule

// File: tb/tb_evm_result_reader.sv
// tb_evm_result_reader: reader plus a behavioural voting unit, with a
// timeline reference model checked every cycle.
module tb_evm_result_reader;

  localparam int H = 12;
  localparam int S = 2;
  localparam int P = H + S + 1;
  localparam int DONE_C = 3 + 6 * P;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  result_in = 8'd0;
  logic        mode_out;
  logic [5:0]  cand_btn;
  logic        busy;
  logic        tally_valid;
  logic [2:0]  tally_idx;
  logic [7:0]  tally_data;
  logic        done;
  logic [10:0] total;
`ifdef EVM_READER_WINNER_EN
  logic [2:0]  winner_idx;
  logic [7:0]  winner_votes;
`endif

  evm_result_reader #(
    .HOLD_CYCLES   (H),
    .SETTLE_CYCLES (S)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .result_in   (result_in),
    .mode_out    (mode_out),
    .cand_btn    (cand_btn),
    .busy        (busy),
    .tally_valid (tally_valid),
    .tally_idx   (tally_idx),
    .tally_data  (tally_data),
    .done        (done),
`ifdef EVM_READER_WINNER_EN
    .winner_idx   (winner_idx),
    .winner_votes (winner_votes),
`endif
    .total       (total)
  );

  always #5 clock = ~clock;

  int ntest = 0;
  int nfail = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // Behavioural voting unit: a button held 10 cycles is one press.
  bit [7:0] vu_cnt [6];
  int       hc [6];
  logic [5:0] vbtn;
  logic       vu_clr;

  always @(posedge clock) begin
    for (int i = 0; i < 6; i++) begin
      if (vu_clr) vu_cnt[i] <= 8'd0;
      if ((cand_btn[i] | vbtn[i]) === 1'b1) begin
        hc[i] <= hc[i] + 1;
        if (hc[i] == 9) begin
          if (mode_out === 1'b1) result_in <= vu_cnt[i];
          else vu_cnt[i] <= vu_cnt[i] + 8'd1;
        end
      end else begin
        hc[i] <= 0;
      end
    end
  end

  // Reference model: phase counter since the accepting edge.
  bit        chk_en = 0;
  bit        act = 0;
  int        ph = 0;
  int        snap [6];
  logic      e_busy, e_mode, e_tv, e_done;
  logic [5:0] e_cand;
  int        e_tidx, e_tdata, e_total, e_wi, e_wv;

  always @(posedge clock) begin
    e_tv = 1'b0;
    if (reset === 1'b1) begin
      chk_en = 1;
      act = 0; ph = 0;
      e_tidx = 0; e_tdata = 0; e_total = 0; e_wi = 0; e_wv = 0;
    end else begin
      if ((!act || ph >= DONE_C) && start === 1'b1) begin
        act = 1; ph = 1;
        e_total = 0; e_wi = 0; e_wv = 0;
        for (int k = 0; k < 6; k++) snap[k] = vu_cnt[k];
      end else if (act && ph < DONE_C) begin
        ph++;
      end else begin
        act = 0;
      end
      for (int k = 0; k < 6; k++) begin
        if (act && ph == 2 + P * (k + 1)) begin
          e_tv = 1'b1;
          e_tidx = k;
          e_tdata = snap[k];
          e_total += snap[k];
          if (snap[k] > e_wv) begin
            e_wv = snap[k];
            e_wi = k;
          end
        end
      end
    end
    e_busy = act && ph >= 1 && ph < DONE_C;
    e_mode = e_busy;
    e_done = act && ph == DONE_C;
    e_cand = 6'd0;
    if (act && ph >= 2 && ph <= 1 + 6 * P && (ph - 2) % P < H)
      e_cand = 6'd1 << ((ph - 2) / P);
  end

  // Compare process and strobe bookkeeping.
  int got_t [8];
  int n_tv = 0;
  int n_done = 0;

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("mode_out", mode_out, e_mode);
      chk("cand_btn", cand_btn, e_cand);
      chk("tally_valid", tally_valid, e_tv);
      chk("done", done, e_done);
      chk("tally_idx", tally_idx, e_tidx);
      chk("tally_data", tally_data, e_tdata);
      chk("total", total, e_total);
`ifdef EVM_READER_WINNER_EN
      chk("winner_idx", winner_idx, e_wi);
      chk("winner_votes", winner_votes, e_wv);
`endif
      if (cand_btn !== 6'd0) begin
        chk("mode_with_btn", mode_out, 1);
        chk("btn_onehot", ($countones(cand_btn) <= 1), 1);
      end
      if (tally_valid === 1'b1) begin
        got_t[tally_idx] = tally_data;
        n_tv++;
      end
      if (done === 1'b1) n_done++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic vu_clear();
    vu_clr = 1'b1;
    tick(1);
    vu_clr = 1'b0;
  endtask

  task automatic cast_set(input int v [6]);
    for (int k = 0; k < 6; k++) begin
      repeat (v[k]) begin
        vbtn[k] = 1'b1;
        tick(11);
        vbtn[k] = 1'b0;
        tick(1);
      end
    end
  endtask

  task automatic wait_done(input int s, input bit poke, output int lat);
    bit seen;
    seen = 0;
    lat = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (poke && cyc - s < 80) start = ($urandom % 4 == 0);
      else start = 1'b0;
      tick(1);
      if (done === 1'b1) begin
        seen = 1;
        lat = cyc - s;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
  endtask

  task automatic do_read(input bit poke, output int lat);
    int s;
    s = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(s, poke, lat);
    tick(2);
  endtask

  task automatic chk_tallies(input string nm, input int v [6]);
    for (int k = 0; k < 6; k++) chk(nm, got_t[k], v[k]);
  endtask

  int lat;
  int s0;
  int vmain [6];
  int vr [6];
  int vmax [6];

  initial begin
    reset = 1'b1;
    start = 1'b1;
    vbtn = 6'd0;
    vu_clr = 1'b1;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_mode", mode_out, 0);
    chk("rst_btn", cand_btn, 0);
    chk("rst_total", total, 0);
    chk("rst_tdata", tally_data, 0);
    reset = 1'b0;
    start = 1'b0;
    vu_clr = 1'b0;
    tick(3);
    chk("rst_wins_start", busy, 0);

    vmain = '{3, 0, 7, 1, 255, 2};
    cast_set(vmain);
    n_tv = 0; n_done = 0;
    do_read(0, lat);
    chk("latency", lat, 93);
    chk_tallies("main_tally", vmain);
    chk("main_total", total, 268);
    chk("main_ntv", n_tv, 6);
    chk("main_ndone", n_done, 1);

    n_tv = 0;
    do_read(0, lat);
    chk_tallies("reread_tally", vmain);
    chk("reread_ntv", n_tv, 6);

    n_tv = 0; n_done = 0;
    s0 = cyc;
    start = 1'b1;
    tick(5);
    start = 1'b0;
    while (cyc - s0 < 40) tick(1);
    start = 1'b1;
    tick(1);
    wait_done(s0, 0, lat);
    chk("held_latency", lat, 93);
    tick(20);
    chk("held_ntv", n_tv, 6);
    chk("held_ndone", n_done, 1);

    n_tv = 0; n_done = 0;
    s0 = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    while (cyc - s0 < 36) tick(1);
    chk("press3_btn", cand_btn, 6'b000100);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("abort_btn", cand_btn, 0);
    chk("abort_mode", mode_out, 0);
    chk("abort_busy", busy, 0);
    tick(100);
    chk("abort_ntv", n_tv, 2);
    chk("abort_ndone", n_done, 0);
    do_read(0, lat);
    chk_tallies("after_abort", vmain);
    chk("after_abort_total", total, 268);

    for (int it = 0; it < 3; it++) begin
      vu_clear();
      for (int k = 0; k < 6; k++) vr[k] = $urandom_range(0, 12);
      cast_set(vr);
      n_tv = 0; n_done = 0;
      do_read(1, lat);
      chk_tallies("rand_tally", vr);
      chk("rand_ntv", n_tv, 6);
      chk("rand_ndone", n_done, 1);
    end

    vu_clear();
    vmax = '{255, 255, 255, 255, 255, 255};
    cast_set(vmax);
    do_read(0, lat);
    chk("max_total", total, 1530);
    chk_tallies("max_tally", vmax);

`ifdef EVM_READER_WINNER_EN
    vu_clear();
    vr = '{5, 9, 9, 2, 0, 1};
    cast_set(vr);
    do_read(0, lat);
    chk("win_idx", winner_idx, 1);
    chk("win_votes", winner_votes, 9);
    vu_clear();
    do_read(0, lat);
    chk("win0_idx", winner_idx, 0);
    chk("win0_votes", winner_votes, 0);
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/evm_result_reader.md
EVM_RESULT_READER -- requirements
Module: evm_result_reader

Interface
REQ-001 Parameter HOLD_CYCLES, default 12: cycles each candidate button is held high; SHALL be >= 12 so the debounce produces exactly one valid press.
REQ-002 Parameter SETTLE_CYCLES, default 2: cycles between button release and result capture; SHALL be >= 2.
REQ-003 clock  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to read all six tallies.
REQ-006 result_in  input  8  result bus from the voting unit.
REQ-007 mode_out  output  1  drives voting-unit mode (1 = result mode).
REQ-008 cand_btn  output  6  one-hot candidate press lines; bit i = candidate i+1.
REQ-009 busy  output  1  high from start acceptance until done.
REQ-010 tally_valid  output  1  one-cycle strobe, tally_idx/tally_data valid.
REQ-011 tally_idx  output  3  candidate index 0..5.
REQ-012 tally_data  output  8  captured vote count.
REQ-013 done  output  1  one-cycle strobe after the sixth tally.
REQ-014 total  output  11  sum of all captured tallies, held until next start.

Function
REQ-015 FSM states IDLE, ARM, PRESS, SETTLE, CAPTURE, FINISH.
REQ-016 IDLE: start=1 -> ARM next cycle; busy=1, total cleared to 0, index cleared to 0.
REQ-017 ARM: exactly one cycle; mode_out=1, cand_btn=0 -> PRESS.
REQ-018 PRESS: cand_btn = one-hot(index) for HOLD_CYCLES cycles, mode_out=1 -> SETTLE.
REQ-019 SETTLE: cand_btn=0 for SETTLE_CYCLES cycles -> CAPTURE.
REQ-020 CAPTURE: one cycle; tally_data<=result_in, tally_idx<=index, tally_valid=1 next cycle, total<=total+result_in (zero-extended, no overflow possible: max 1530).
REQ-021 CAPTURE with index<5 -> index+1, PRESS; index==5 -> FINISH.
REQ-022 FINISH: one cycle; done=1, busy=0, mode_out=0 from following cycle -> IDLE.
REQ-023 mode_out SHALL be 1 on every cycle any cand_btn bit is 1, and at least one cycle before and after; a button press in mode 0 would cast a vote.
REQ-024 At most one cand_btn bit high in any cycle.
REQ-025 start while busy ignored; no restart, no queueing.
REQ-026 Latency start -> done = 1 + 1 + 6*(HOLD_CYCLES+SETTLE_CYCLES+1) + 1 cycles (default 93).
REQ-027 tally_data, tally_idx, total hold their last value between strobes.

Reset
REQ-028 reset=1 -> IDLE; mode_out=0, cand_btn=0, busy=0, done=0, tally_valid=0, tally_idx=0, tally_data=0, total=0, timer=0.
REQ-029 Reset mid-read aborts immediately; buttons released same edge; no tally_valid or done strobes emitted.
REQ-030 reset and start same cycle: reset wins.

Configuration
REQ-031 Macro EVM_READER_WINNER_EN defined: adds outputs winner_idx (3) and winner_votes (8), updated in CAPTURE when result_in > current max (strict, so ties keep lowest index), cleared on start/reset, valid at done.
REQ-032 Macro undefined: those ports and the comparator are absent; all other behaviour identical.

Structure
REQ-033 Shared package evm_pkg: NUM_CAND=6, VOTE_W=8, TOTAL_W=11, FSM state enum.
REQ-034 One sub-module evm_reader_timer: loadable down-counter with zero flag, used for PRESS and SETTLE durations.

Verification
REQ-035 Bench connects the reader to the existing voting-unit top, casts votes 3,0,7,1,255,2 in mode 0 first, then pulses start -> tallies 3,0,7,1,255,2 on idx 0..5, total=268, done at cycle 93.
REQ-036 Full read -> voting-unit counters unchanged afterward (re-read gives identical tallies); mode_out=1 on every cycle any cand_btn bit is 1.
REQ-037 start held 5 cycles, and start pulsed at cycle 40 -> exactly one read, six strobes, one done.
REQ-038 reset asserted during third PRESS -> next cycle cand_btn=0, mode_out=0, busy=0, no further strobes; later start -> full correct read.
REQ-039 EVM_READER_WINNER_EN, votes 5,9,9,2,0,1 -> winner_idx=1, winner_votes=9; all-zero votes -> winner_idx=0, winner_votes=0.
REQ-040 All counts 255 -> total=1530, no wrap.
